// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score table block.
//   op_e      : command encodings carried on the Op input
//   state_e   : control FSM state encoding
//   calc_id_w : width of a player-ID field for a given slot count (min 1 bit)
// -----------------------------------------------------------------------------
package score_pkg;

    typedef enum logic [1:0] {
        OP_UPDATE       = 2'b00,
        OP_QUERY        = 2'b01,
        OP_CLEAR_PLAYER = 2'b10,
        OP_CLEAR_ALL    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_COMMIT = 3'd2,
        ST_SCAN   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // A single-slot table would give clog2 = 0; keep at least one ID bit.
    function automatic int calc_id_w(input int num_players);
        int w;
        w = $clog2(num_players);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/score_store.sv
// -----------------------------------------------------------------------------
// score_store
// NUM_PLAYERS x SCORE_W register array holding each player's best score.
// Ports:
//   i_clk        clock; writes and clear-all take effect on the rising edge
//   i_rst_n      asynchronous active-low reset, zeroes every slot
//   i_clear_all  synchronous strobe zeroing every slot
//   i_wr_en      write strobe for i_wr_addr / i_wr_data
//   i_wr_addr    write slot index
//   i_wr_data    write data
//   i_rd_addr    read slot index
//   o_rd_data    combinational read data (0 for an index beyond the table)
// -----------------------------------------------------------------------------
module score_store
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS = 8,
    parameter int SCORE_W     = 7,
    parameter int ID_W        = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear_all,
    input  logic               i_wr_en,
    input  logic [ID_W-1:0]    i_wr_addr,
    input  logic [SCORE_W-1:0] i_wr_data,
    input  logic [ID_W-1:0]    i_rd_addr,
    output logic [SCORE_W-1:0] o_rd_data
);

    logic [SCORE_W-1:0] r_mem [NUM_PLAYERS];

    logic w_wr_in_range;
    logic w_rd_in_range;

    // When NUM_PLAYERS is not a power of two the ID field can address
    // slots that do not exist; those accesses are suppressed here.
    assign w_wr_in_range = (int'(i_wr_addr) < NUM_PLAYERS);
    assign w_rd_in_range = (int'(i_rd_addr) < NUM_PLAYERS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear_all) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = w_rd_in_range ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/score_table.sv
// -----------------------------------------------------------------------------
// score_table
// Per-player best-score table with a running overall maximum.
// One command at a time: IDLE accepts, LOOKUP reads the target slot,
// COMMIT applies the change, SCAN (only when the overall holder is cleared)
// walks every slot to rebuild the maximum, DONE pulses o_done.
// Ports:
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   i_valid          command present; accepted when o_ready is high
//   i_op             00 UPDATE, 01 QUERY, 10 CLEAR_PLAYER, 11 CLEAR_ALL
//   i_player_id      target slot
//   i_current_score  score submitted with UPDATE
//   o_ready          high only while idle
//   o_done           one-cycle completion pulse
//   o_personel_best  target slot's best after the command
//   o_highest_score  overall maximum of all slots
//   o_player_won     slot holding o_highest_score
//   o_new_personal   UPDATE raised the target's best (valid with o_done)
//   o_new_high       UPDATE raised the overall best (valid with o_done)
//   o_id_error       target slot does not exist; table untouched
// -----------------------------------------------------------------------------
module score_table
    import score_pkg::*;
#(
    parameter int  NUM_PLAYERS = 8,
    parameter int  SCORE_W     = 7,
    localparam int ID_W        = calc_id_w(NUM_PLAYERS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [1:0]         i_op,
    input  logic [ID_W-1:0]    i_player_id,
    input  logic [SCORE_W-1:0] i_current_score,
    output logic               o_ready,
    output logic               o_done,
    output logic [SCORE_W-1:0] o_personel_best,
    output logic [SCORE_W-1:0] o_highest_score,
    output logic [ID_W-1:0]    o_player_won,
    output logic               o_new_personal,
    output logic               o_new_high,
    output logic               o_id_error
);

    state_e             r_state;
    state_e             w_next_state;

    op_e                r_op;
    logic [ID_W-1:0]    r_id;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_lookup_best;
    logic               r_id_error;

    logic [SCORE_W-1:0] r_personel_best;
    logic [SCORE_W-1:0] r_highest_score;
    logic [ID_W-1:0]    r_player_won;
    logic               r_new_personal;
    logic               r_new_high;

    logic [ID_W-1:0]    r_scan_idx;
    logic [SCORE_W-1:0] r_scan_max;
    logic [ID_W-1:0]    r_scan_id;

    logic               w_store_wr_en;
    logic [SCORE_W-1:0] w_store_wr_data;
    logic               w_store_clear_all;
    logic [ID_W-1:0]    w_rd_addr;
    logic [SCORE_W-1:0] w_rd_data;

    logic               w_id_bad;
    logic               w_need_scan;
    logic               w_scan_last;
    logic               w_scan_better;

    score_store #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .SCORE_W     (SCORE_W),
        .ID_W        (ID_W)
    ) u_store (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear_all (w_store_clear_all),
        .i_wr_en     (w_store_wr_en),
        .i_wr_addr   (r_id),
        .i_wr_data   (w_store_wr_data),
        .i_rd_addr   (w_rd_addr),
        .o_rd_data   (w_rd_data)
    );

    // The read port follows the scan pointer while rebuilding the maximum,
    // otherwise it looks at the command's target slot.
    assign w_rd_addr     = (r_state == ST_SCAN) ? r_scan_idx : r_id;

    assign w_id_bad      = (int'(r_id) >= NUM_PLAYERS);
    assign w_scan_last   = (r_scan_idx == ID_W'(NUM_PLAYERS - 1));
    assign w_scan_better = (w_rd_data > r_scan_max);

    // A rescan is only needed when the current overall holder is cleared
    // while holding a nonzero score; any other clear leaves the max intact.
    assign w_need_scan   = (r_op == OP_CLEAR_PLAYER) && !r_id_error &&
                           (r_id == r_player_won) && (r_highest_score != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the store write strobes issued in COMMIT.
    always_comb begin
        w_next_state      = r_state;
        w_store_wr_en     = 1'b0;
        w_store_wr_data   = '0;
        w_store_clear_all = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_next_state = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (!r_id_error) begin
                    case (r_op)
                        OP_UPDATE: begin
                            if (r_score > r_lookup_best) begin
                                w_store_wr_en   = 1'b1;
                                w_store_wr_data = r_score;
                            end
                        end
                        OP_CLEAR_PLAYER: begin
                            w_store_wr_en   = 1'b1;
                            w_store_wr_data = '0;
                        end
                        OP_CLEAR_ALL: begin
                            w_store_clear_all = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                w_next_state = w_need_scan ? ST_SCAN : ST_DONE;
            end
            ST_SCAN: begin
                if (w_scan_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Command capture, lookup, result registers and the scan accumulator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op            <= OP_UPDATE;
            r_id            <= '0;
            r_score         <= '0;
            r_lookup_best   <= '0;
            r_id_error      <= 1'b0;
            r_personel_best <= '0;
            r_highest_score <= '0;
            r_player_won    <= '0;
            r_new_personal  <= 1'b0;
            r_new_high      <= 1'b0;
            r_scan_idx      <= '0;
            r_scan_max      <= '0;
            r_scan_id       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_op           <= op_e'(i_op);
                        r_id           <= i_player_id;
                        r_score        <= i_current_score;
                        r_new_personal <= 1'b0;
                        r_new_high     <= 1'b0;
                        r_id_error     <= 1'b0;
                    end
                end
                ST_LOOKUP: begin
                    r_id_error    <= w_id_bad;
                    r_lookup_best <= w_id_bad ? '0 : w_rd_data;
                end
                ST_COMMIT: begin
                    if (r_id_error) begin
                        r_personel_best <= '0;
                    end else begin
                        case (r_op)
                            OP_UPDATE: begin
                                if (r_score > r_lookup_best) begin
                                    r_personel_best <= r_score;
                                    r_new_personal  <= 1'b1;
                                end else begin
                                    r_personel_best <= r_lookup_best;
                                end
                                // Strictly greater, so a tie keeps the earlier holder.
                                if (r_score > r_highest_score) begin
                                    r_highest_score <= r_score;
                                    r_player_won    <= r_id;
                                    r_new_high      <= 1'b1;
                                end
                            end
                            OP_QUERY: begin
                                r_personel_best <= r_lookup_best;
                            end
                            OP_CLEAR_PLAYER: begin
                                r_personel_best <= '0;
                                if (w_need_scan) begin
                                    r_scan_idx <= '0;
                                    r_scan_max <= '0;
                                    r_scan_id  <= '0;
                                end
                            end
                            OP_CLEAR_ALL: begin
                                r_personel_best <= '0;
                                r_highest_score <= '0;
                                r_player_won    <= '0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_SCAN: begin
                    // Ascending walk with a strict compare gives the lowest ID on ties;
                    // the last slot is folded in directly when publishing the result.
                    if (w_scan_better) begin
                        r_scan_max <= w_rd_data;
                        r_scan_id  <= r_scan_idx;
                    end
                    if (w_scan_last) begin
                        r_highest_score <= w_scan_better ? w_rd_data  : r_scan_max;
                        r_player_won    <= w_scan_better ? r_scan_idx : r_scan_id;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready         = (r_state == ST_IDLE);
    assign o_done          = (r_state == ST_DONE);
    assign o_personel_best = r_personel_best;
    assign o_highest_score = r_highest_score;
    assign o_player_won    = r_player_won;
    assign o_new_personal  = r_new_personal;
    assign o_new_high      = r_new_high;
    assign o_id_error      = r_id_error;

endmodule

// File: tb/tb_score_table.sv
// -----------------------------------------------------------------------------
// tb_score_table
// Scoreboard bench for score_table (8 slots, 7-bit scores) plus a small
// six-slot instance for out-of-range player IDs.
// -----------------------------------------------------------------------------
module tb_score_table;

    localparam int NP = 8;
    localparam int SW = 7;
    localparam int IW = 3;

    typedef struct {
        int accept;
        int lat;
        int pb;
        int hi;
        int won;
        int np;
        int nh;
        int ierr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [1:0]    op;
    logic [IW-1:0] pid;
    logic [SW-1:0] score;
    logic          o_ready, o_done, o_new_personal, o_new_high, o_id_error;
    logic [SW-1:0] o_personel_best, o_highest_score;
    logic [IW-1:0] o_player_won;

    logic          valid6;
    logic [1:0]    op6;
    logic [2:0]    pid6;
    logic [SW-1:0] score6;
    logic          o_ready6, o_done6, o_new_personal6, o_new_high6, o_id_error6;
    logic [SW-1:0] o_personel_best6, o_highest_score6;
    logic [2:0]    o_player_won6;

    exp_t expQ[$];
    int   mTable[NP];
    int   mHi;
    int   mWon;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   readyPending = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    score_table #(.NUM_PLAYERS(NP), .SCORE_W(SW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_valid         (valid),
        .i_op            (op),
        .i_player_id     (pid),
        .i_current_score (score),
        .o_ready         (o_ready),
        .o_done          (o_done),
        .o_personel_best (o_personel_best),
        .o_highest_score (o_highest_score),
        .o_player_won    (o_player_won),
        .o_new_personal  (o_new_personal),
        .o_new_high      (o_new_high),
        .o_id_error      (o_id_error)
    );

    score_table #(.NUM_PLAYERS(6), .SCORE_W(SW)) dut6 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_valid         (valid6),
        .i_op            (op6),
        .i_player_id     (pid6),
        .i_current_score (score6),
        .o_ready         (o_ready6),
        .o_done          (o_done6),
        .o_personel_best (o_personel_best6),
        .o_highest_score (o_highest_score6),
        .o_player_won    (o_player_won6),
        .o_new_personal  (o_new_personal6),
        .o_new_high      (o_new_high6),
        .o_id_error      (o_id_error6)
    );

    task automatic checkOutput(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0d want=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NP; i++) mTable[i] = 0;
        mHi  = 0;
        mWon = 0;
    endfunction

    // Reference behaviour: a plain array of bests and a tracked overall max.
    function automatic exp_t predict(input int o, input int id, input int sc);
        exp_t e;
        e.accept = 0; e.lat = 3; e.pb = 0; e.np = 0; e.nh = 0; e.ierr = 0;
        case (o)
            0: begin
                if (sc > mTable[id]) begin
                    mTable[id] = sc;
                    e.np = 1;
                end
                e.pb = mTable[id];
                if (sc > mHi) begin
                    mHi  = sc;
                    mWon = id;
                    e.nh = 1;
                end
            end
            1: e.pb = mTable[id];
            2: begin
                mTable[id] = 0;
                if (id == mWon && mHi != 0) begin
                    e.lat = 3 + NP;
                    mHi  = 0;
                    mWon = 0;
                    for (int i = 0; i < NP; i++) begin
                        if (mTable[i] > mHi) begin
                            mHi  = mTable[i];
                            mWon = i;
                        end
                    end
                end
            end
            default: modelReset();
        endcase
        e.hi  = mHi;
        e.won = mWon;
        return e;
    endfunction

    task automatic applyStimulus(input int o, input int id, input int sc, input bit holdValid);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!o_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) begin
            checkOutput("ready_timeout", int'(o_ready), 1);
            return;
        end
        op    = 2'(o);
        pid   = IW'(id);
        score = SW'(sc);
        valid = 1'b1;
        e = predict(o, id, sc);
        e.accept = cyc + 1;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        op    = 2'($urandom);
        pid   = IW'($urandom);
        score = SW'($urandom);
        if (holdValid) begin
            waited = 0;
            while (!o_done && waited < 40) begin
                @(negedge clk);
                waited++;
            end
        end
        valid = 1'b0;
    endtask

    task automatic runDut6(input int o, input int id, input int sc,
                           input int wantErr, input int wantHi, input int wantWon, input int wantPb);
        int waited;
        @(negedge clk);
        op6    = 2'(o);
        pid6   = 3'(id);
        score6 = SW'(sc);
        valid6 = 1'b1;
        @(posedge clk);
        #1;
        valid6 = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!o_done6 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("six_done", int'(o_done6), 1);
        checkOutput("six_id_error", int'(o_id_error6), wantErr);
        checkOutput("six_highest", int'(o_highest_score6), wantHi);
        checkOutput("six_won", int'(o_player_won6), wantWon);
        if (wantPb >= 0) checkOutput("six_pb", int'(o_personel_best6), wantPb);
        if (wantErr == 1) checkOutput("six_new_personal", int'(o_new_personal6), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, int'(o_ready), 1);
        checkOutput({tag, "_done"}, int'(o_done), 0);
        checkOutput({tag, "_pb"}, int'(o_personel_best), 0);
        checkOutput({tag, "_highest"}, int'(o_highest_score), 0);
        checkOutput({tag, "_won"}, int'(o_player_won), 0);
        checkOutput({tag, "_flags"}, int'({o_new_personal, o_new_high, o_id_error}), 0);
    endtask

    // Monitor: pops one expectation per Done pulse and checks Ready the cycle after.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                readyPending = 1'b0;
            end else begin
                if (readyPending) begin
                    checkOutput("ready_after_done", int'(o_ready), 1);
                    readyPending = 1'b0;
                end
                if (o_done) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("latency", cyc - e.accept + 1, e.lat);
                        checkOutput("personel_best", int'(o_personel_best), e.pb);
                        checkOutput("highest_score", int'(o_highest_score), e.hi);
                        checkOutput("player_won", int'(o_player_won), e.won);
                        checkOutput("new_personal", int'(o_new_personal), e.np);
                        checkOutput("new_high", int'(o_new_high), e.nh);
                        checkOutput("id_error", int'(o_id_error), e.ierr);
                        readyPending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int r;
        int o;
        int sc;
        int waited;
        int picks[4];
        picks[0] = 0; picks[1] = 50; picks[2] = 127; picks[3] = 1;

        rst_n = 1'b0; valid = 1'b0; op = '0; pid = '0; score = '0;
        valid6 = 1'b0; op6 = '0; pid6 = '0; score6 = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkAllZero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("after_reset");

        // Six-slot build: IDs 6 and 7 do not exist.
        runDut6(0, 6, 99, 1, 0, 0, -1);
        runDut6(0, 2, 10, 0, 10, 2, 10);
        runDut6(0, 7, 120, 1, 10, 2, -1);
        runDut6(1, 2, 0, 0, 10, 2, 10);

        // Directed walk-through on the 8-slot build.
        applyStimulus(0, 3, 50, 1'b0);
        applyStimulus(0, 5, 50, 1'b0);
        applyStimulus(0, 5, 40, 1'b0);
        applyStimulus(2, 3, 0, 1'b1);
        applyStimulus(0, 7, 127, 1'b0);
        applyStimulus(1, 7, 0, 1'b0);
        applyStimulus(2, 6, 0, 1'b0);
        applyStimulus(3, 0, 0, 1'b0);
        applyStimulus(1, 5, 0, 1'b0);

        // Reset in the middle of a rescan.
        applyStimulus(0, 2, 60, 1'b0);
        applyStimulus(0, 4, 30, 1'b0);
        applyStimulus(2, 2, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllZero("mid_scan_reset");
        expQ.delete();
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(1, 4, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 11) o = 0;
            else if (r < 15) o = 1;
            else if (r < 19) o = 2;
            else o = 3;
            if ($urandom_range(0, 2) == 0) sc = picks[$urandom_range(0, 3)];
            else sc = int'($urandom_range(0, 127));
            applyStimulus(o, int'($urandom_range(0, NP - 1)), sc, 1'($urandom_range(0, 3) == 0));
        end

        waited = 0;
        while (expQ.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("pending_at_end", expQ.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
